// File: rtl/strobe_serializer_pkg.sv
// Shared types and sizing helpers for the strobe serializer.
// State encoding plus counter-width functions used by the top and the phase counter.
package strobe_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Bit counter must be able to index every bit of a word, parity included.
    function automatic int bit_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    // One spare bit keeps DIV=1 (load value 0) legal.
    function automatic int phase_cnt_width(input int div);
        return $clog2(div) + 1;
    endfunction

endpackage

// File: rtl/strobe_serializer_if.sv
// Word-in / serial-out bundle for the strobe serializer.
// master drives the parallel word; slave is the serializer itself.
interface strobe_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             strobe_out;
    logic             data_out;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  strobe_out,
        input  data_out,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output strobe_out,
        output data_out,
        output busy
    );
endinterface

// File: rtl/strobe_serializer_phase_cnt.sv
// Loadable down-counter timing one SETUP or HOLD phase of DIV clk cycles.
// load has priority; counting stops at zero, and zero is flagged combinationally.
module strobe_serializer_phase_cnt
    import strobe_serializer_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic zero
);
    localparam int             PW       = phase_cnt_width(DIV);
    localparam logic [PW-1:0]  LOAD_VAL = PW'(DIV - 1);

    logic [PW-1:0] count_reg;
    logic [PW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = LOAD_VAL;
        end else if (en && (count_reg != '0)) begin
            count_next = count_reg - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/strobe_serializer.sv
// MSB-first serializer emitting a data bit plus a registered qualifying strobe.
// Optional parity bit appended when STROBE_SERIALIZER_PARITY_EN is defined.
module strobe_serializer
    import strobe_serializer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    strobe_serializer_if.slave    bus
);
`ifdef STROBE_SERIALIZER_PARITY_EN
    localparam int FB = WIDTH + 1;
`else
    localparam int FB = WIDTH;
`endif
    localparam int             BW       = bit_cnt_width(WIDTH);
    localparam logic [BW-1:0]  LAST_BIT = BW'(FB - 1);

    state_t          state_reg;
    state_t          state_next;
    logic [FB-1:0]   shift_reg;
    logic [FB-1:0]   shift_next;
    logic [BW-1:0]   bit_cnt_reg;
    logic [BW-1:0]   bit_cnt_next;
    logic            strobe_reg;
    logic            strobe_next;
    logic            busy_reg;
    logic            busy_next;

    logic            ready;
    logic            take;
    logic            phase_load;
    logic            phase_zero;
    logic [FB-1:0]   load_word;

`ifdef STROBE_SERIALIZER_PARITY_EN
    // Even parity rides in the LSB so it simply shifts out after the data bits.
    assign load_word = {bus.in_data, ^bus.in_data};
`else
    assign load_word = bus.in_data;
`endif

    assign ready = (state_reg == IDLE) && !rst;
    assign take  = bus.in_valid && ready;

    strobe_serializer_phase_cnt #(
        .DIV (DIV)
    ) u_phase_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (phase_load),
        .en   (state_reg != IDLE),
        .zero (phase_zero)
    );

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        strobe_next  = strobe_reg;
        busy_next    = busy_reg;
        phase_load   = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (take) begin
                    shift_next   = load_word;
                    bit_cnt_next = '0;
                    busy_next    = 1'b1;
                    phase_load   = 1'b1;
                    state_next   = SETUP;
                end
            end
            SETUP: begin
                if (phase_zero) begin
                    strobe_next = 1'b1;
                    phase_load  = 1'b1;
                    state_next  = HOLD;
                end
            end
            HOLD: begin
                if (phase_zero) begin
                    strobe_next = 1'b0;
                    if (bit_cnt_reg == LAST_BIT) begin
                        // Shift register is left alone so data_out keeps the last bit.
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        shift_next   = {shift_reg[FB-2:0], 1'b0};
                        bit_cnt_next = bit_cnt_reg + BW'(1);
                        phase_load   = 1'b1;
                        state_next   = SETUP;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            strobe_reg  <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            strobe_reg  <= strobe_next;
            busy_reg    <= busy_next;
        end
    end

    // data_out is the registered MSB of the shift register, so it moves only on load or shift.
    assign bus.data_out   = shift_reg[FB-1];
    assign bus.strobe_out = strobe_reg;
    assign bus.busy       = busy_reg;
    assign bus.in_ready   = ready;

endmodule

// File: tb/tb_strobe_serializer.sv
// Directed self-checking bench for strobe_serializer (WIDTH=8, DIV=2).
// Edges are numbered by a posedge counter; outputs are sampled 1ns after each negedge.
module tb_strobe_serializer;
    import strobe_serializer_pkg::*;

    localparam int WIDTH = 8;
    localparam int DIV   = 2;
`ifdef STROBE_SERIALIZER_PARITY_EN
    localparam int FB = WIDTH + 1;
`else
    localparam int FB = WIDTH;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    strobe_serializer_if #(.WIDTH(WIDTH)) bus ();

    strobe_serializer #(
        .WIDTH (WIDTH),
        .DIV   (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    int edge_cnt   = 0;
    int acc_q[$];
    int rise_q[$];
    int rise_bit_q[$];
    int fall_q[$];
    int ready_q[$];
    int hold_viol  = 0;
    logic strobe_prev = 1'b0;
    logic ready_prev  = 1'b0;
    logic data_prev   = 1'b0;

    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        if (bus.in_valid && bus.in_ready) acc_q.push_back(edge_cnt + 1);
    end

    always @(negedge clk) begin
        if (bus.strobe_out && !strobe_prev) begin
            rise_q.push_back(edge_cnt);
            rise_bit_q.push_back(int'(bus.data_out));
        end
        if (!bus.strobe_out && strobe_prev) fall_q.push_back(edge_cnt);
        if (bus.in_ready && !ready_prev) ready_q.push_back(edge_cnt);
        if (strobe_prev && bus.strobe_out && (bus.data_out != data_prev)) hold_viol <= hold_viol + 1;
        strobe_prev <= bus.strobe_out;
        ready_prev  <= bus.in_ready;
        data_prev   <= bus.data_out;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_q();
        acc_q.delete();
        rise_q.delete();
        rise_bit_q.delete();
        fall_q.delete();
        ready_q.delete();
    endtask

    function automatic logic exp_bit(input logic [7:0] w, input int k);
        if (k < WIDTH) return w[WIDTH-1-k];
        return ^w;
    endfunction

    task automatic wait_acc(input int n);
        for (int i = 0; i < 200 && acc_q.size() < n; i++) next_cyc();
        check_val("accept_seen", acc_q.size(), n);
    endtask

    task automatic send_word(input logic [7:0] w, output int t0);
        int n0;
        n0 = acc_q.size();
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        wait_acc(n0 + 1);
        bus.in_valid = 1'b0;
        t0 = (acc_q.size() > n0) ? acc_q[n0] : 0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && bus.busy; i++) next_cyc();
        check_val("idle_reached", bus.busy, 0);
        next_cyc();
    endtask

    task automatic check_frame(input string tag, input logic [7:0] w, input int t0, input int base);
        for (int k = 0; k < FB; k++) begin
            if (base + k < rise_q.size()) begin
                check_val($sformatf("%s_rise%0d", tag, k), rise_q[base+k] - t0, DIV + 2*DIV*k);
                check_val($sformatf("%s_bit%0d", tag, k), rise_bit_q[base+k], exp_bit(w, k));
            end else begin
                check_val($sformatf("%s_missing%0d", tag, k), rise_q.size(), base + k + 1);
            end
            if (base + k < fall_q.size())
                check_val($sformatf("%s_fall%0d", tag, k), fall_q[base+k] - t0, 2*DIV*(k+1));
        end
    endtask

    initial begin
        int t0;
        bus.in_data  = 8'h5A;
        bus.in_valid = 1'b1;

        // Reset held with in_valid asserted: nothing may move.
        next_cyc();
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            check_val("rst_in_ready", bus.in_ready, 0);
            check_val("rst_strobe", bus.strobe_out, 0);
            check_val("rst_data", bus.data_out, 0);
            check_val("rst_busy", bus.busy, 0);
        end
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        next_cyc();
        check_val("post_rst_in_ready", bus.in_ready, 1);
        check_val("rst_no_transfer", acc_q.size(), 0);
        $display("reset: in_ready=%0b busy=%0b", bus.in_ready, bus.busy);

        // Single word 0xA5.
        clear_q();
        send_word(8'hA5, t0);
        wait_idle();
        check_val("a5_pulses", rise_q.size(), FB);
        check_frame("a5", 8'hA5, t0, 0);
        check_val("a5_ready_rise", (ready_q.size() > 0) ? ready_q[0] - t0 : -1, 2*DIV*FB);
        check_val("a5_data_hold", bus.data_out, exp_bit(8'hA5, FB-1));
        $display("word 0xA5: t0=%0d pulses=%0d", t0, rise_q.size());

        // Back-to-back 0xFF then 0x00 with in_valid held.
        clear_q();
        bus.in_data  = 8'hFF;
        bus.in_valid = 1'b1;
        wait_acc(1);
        bus.in_data  = 8'h00;
        wait_acc(2);
        bus.in_valid = 1'b0;
        wait_idle();
        check_val("b2b_pulses", rise_q.size(), 2*FB);
        if (acc_q.size() == 2 && rise_q.size() == 2*FB && fall_q.size() >= FB) begin
            // in_ready rises at the edge that ends frame 1; that cycle's edge takes word 2.
            check_val("b2b_accept_gap", acc_q[1] - acc_q[0], 2*DIV*FB + 1);
            check_val("b2b_low_gap", rise_q[FB] - fall_q[FB-1], DIV + 1);
            check_frame("ff", 8'hFF, acc_q[0], 0);
            check_frame("00", 8'h00, acc_q[1], FB);
        end
        $display("back-to-back 0xFF/0x00: pulses=%0d", rise_q.size());

        // in_valid with 0x3C mid-frame is ignored until in_ready rises.
        clear_q();
        send_word(8'h81, t0);
        repeat (5) next_cyc();
        bus.in_data  = 8'h3C;
        bus.in_valid = 1'b1;
        wait_acc(2);
        bus.in_valid = 1'b0;
        wait_idle();
        check_val("mid_pulses", rise_q.size(), 2*FB);
        if (acc_q.size() == 2) begin
            check_val("mid_accept_edge", acc_q[1] - t0, 2*DIV*FB + 1);
            check_frame("81", 8'h81, t0, 0);
            check_frame("3c", 8'h3C, acc_q[1], FB);
        end
        $display("mid-frame 0x3C: second accept at +%0d", (acc_q.size() == 2) ? acc_q[1] - t0 : -1);

        // Reset pulse sampled at edge T0+9 aborts the frame.
        clear_q();
        send_word(8'hA5, t0);
        for (int i = 0; i < 50 && edge_cnt < t0 + 8; i++) next_cyc();
        rst = 1'b1;
        next_cyc();
        check_val("abort_edge", edge_cnt - t0, 9);
        check_val("abort_strobe", bus.strobe_out, 0);
        check_val("abort_busy", bus.busy, 0);
        rst = 1'b0;
        repeat (20) next_cyc();
        check_val("abort_rises", rise_q.size(), 2);
        check_val("abort_falls", fall_q.size(), 2);
        check_val("abort_idle_ready", bus.in_ready, 1);
        clear_q();
        send_word(8'h3C, t0);
        wait_idle();
        check_val("after_abort_pulses", rise_q.size(), FB);
        check_frame("re3c", 8'h3C, t0, 0);
        $display("abort at T0+9: recovered word 0x3C pulses=%0d", rise_q.size());

`ifdef STROBE_SERIALIZER_PARITY_EN
        clear_q();
        send_word(8'h01, t0);
        wait_idle();
        check_val("par01_bit8", (rise_bit_q.size() == FB) ? rise_bit_q[FB-1] : -1, 1);
        check_val("par01_ready", (ready_q.size() > 0) ? ready_q[0] - t0 : -1, 36);
        $display("parity word 0x01: pulses=%0d", rise_q.size());
`endif

        check_val("data_stable_while_strobe_high", hold_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
